// File: rtl/dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module: TAP states,
// IR encodings, DTMCS layout and the DMI request frame.
package dtm_pkg;

  localparam int DMI_ABITS = 7;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_DTMCS,
    DR_DMI
  } dr_sel_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;

  localparam logic [1:0] DMI_OP_NOP    = 2'd0;
  localparam logic [1:0] DMI_OP_READ   = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE  = 2'd2;
  localparam logic [1:0] DMI_STAT_BUSY = 2'd3;

  typedef struct packed {
    logic [16:0] zero;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  // Field order matches the DMI shift frame: address on top, op in the LSBs.
  typedef struct packed {
    logic [DMI_ABITS-1:0] addr;
    logic [31:0]          data;
    logic [1:0]           op;
  } dmi_req_t;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Oversamples the JTAG pins into clk, detects tck edges and runs the
// IEEE 1149.1 TAP controller on the synchronised tck rising edge.
module jtag_tap_sync
  import dtm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tck_rise,
  output logic       tck_fall,
  output logic       tdi_s,
  output tap_state_e state
);

  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
  logic                   tck_prev_q, tck_prev_d;
  tap_state_e             state_q, state_d;

  logic tck_s;
  logic tms_s;

  // All three pins go through the same depth so tms/tdi line up with tck.
  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;
  assign state    = state_q;

  always_comb begin
    // NOTE: every *_d is assigned before any condition so no latch is inferred.
    tck_sync_d = (tck_sync_q << 1) | SYNC_STAGES'(tck);
    tms_sync_d = (tms_sync_q << 1) | SYNC_STAGES'(tms);
    tdi_sync_d = (tdi_sync_q << 1) | SYNC_STAGES'(tdi);
    tck_prev_d = tck_s;
    state_d    = state_q;
    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);
    end
  end

  // NOTE: flops use <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
      state_q    <= TEST_LOGIC_RESET;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      tck_prev_q <= tck_prev_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: rtl/dtm_jtag.sv
// JTAG debug transport module: IR/DR scan chains (IDCODE, DTMCS, DMI, BYPASS)
// and the single-outstanding DMI handshake towards the debug module.
module dtm_jtag
  import dtm_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int          ABITS       = DMI_ABITS,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             dmi_start,
  input  logic             dmi_finish,
  output logic [1:0]       dmi_op,
  output logic [ABITS-1:0] dmi_address,
  output logic [31:0]      dmi_data_o,
  input  logic [31:0]      dmi_data_i
);

  localparam int DR_W = ABITS + 34;

  logic       tck_rise;
  logic       tck_fall;
  logic       tdi_s;
  tap_state_e state;

  jtag_tap_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tap (
    .clk     (clk),
    .rst     (rst),
    .tck     (tck),
    .tms     (tms),
    .tdi     (tdi),
    .tck_rise(tck_rise),
    .tck_fall(tck_fall),
    .tdi_s   (tdi_s),
    .state   (state)
  );

  logic [4:0]      ir_q, ir_d;
  logic [4:0]      ir_shift_q, ir_shift_d;
  logic [DR_W-1:0] dr_q, dr_d;
  logic            tdo_q, tdo_d;
  logic            dmi_start_q, dmi_start_d;
  dmi_req_t        req_q, req_d;
  logic            busy_q, busy_d;
  logic [1:0]      sticky_q, sticky_d;
  logic [31:0]     last_rdata_q, last_rdata_d;

  dr_sel_e     dr_sel;
  dtmcs_t      dtmcs_rd;
  dmi_req_t    dmi_in;
  logic        busy_now;
  logic [31:0] rdata_now;
  logic [1:0]  dmi_status;

  always_comb begin
    case (ir_q)
      IR_IDCODE: dr_sel = DR_IDCODE;
      IR_DTMCS:  dr_sel = DR_DTMCS;
      IR_DMI:    dr_sel = DR_DMI;
      default:   dr_sel = DR_BYPASS;
    endcase
  end

  // A completion in the same clk as a capture is folded in before the capture.
  assign busy_now   = busy_q & ~dmi_finish;
  assign rdata_now  = (busy_q && dmi_finish && req_q.op == DMI_OP_READ) ? dmi_data_i
                                                                         : last_rdata_q;
  assign dmi_status = (busy_now || sticky_q == DMI_STAT_BUSY) ? DMI_STAT_BUSY : DMI_OP_NOP;
  assign dmi_in     = dmi_req_t'(dr_q);

  always_comb begin
    dtmcs_rd         = '0;
    dtmcs_rd.idle    = 3'd1;
    dtmcs_rd.dmistat = sticky_q;
    dtmcs_rd.abits   = 6'(ABITS);
    dtmcs_rd.version = 4'd1;
  end

  always_comb begin
    ir_d         = ir_q;
    ir_shift_d   = ir_shift_q;
    dr_d         = dr_q;
    tdo_d        = tdo_q;
    dmi_start_d  = 1'b0;
    req_d        = req_q;
    busy_d       = busy_now;
    sticky_d     = sticky_q;
    last_rdata_d = rdata_now;

    if (state == TEST_LOGIC_RESET) begin
      ir_d = IR_IDCODE;
    end

    if (tck_rise) begin
      case (state)
        CAPTURE_IR: ir_shift_d = 5'b00001;
        SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[4:1]};
        UPDATE_IR:  ir_d = ir_shift_q;
        CAPTURE_DR: begin
          case (dr_sel)
            DR_IDCODE: dr_d = DR_W'(IDCODE_VAL);
            DR_DTMCS:  dr_d = DR_W'(dtmcs_rd);
            DR_DMI: begin
              dr_d = {req_q.addr, rdata_now, dmi_status};
              if (busy_now) sticky_d = DMI_STAT_BUSY;
            end
            default:   dr_d = '0;
          endcase
        end
        SHIFT_DR: begin
          case (dr_sel)
            DR_IDCODE, DR_DTMCS: dr_d = DR_W'({tdi_s, dr_q[31:1]});
            DR_DMI:              dr_d = {tdi_s, dr_q[DR_W-1:1]};
            default:             dr_d = DR_W'(tdi_s);
          endcase
        end
        UPDATE_DR: begin
          if (dr_sel == DR_DTMCS) begin
            if (dr_q[17]) begin
              sticky_d = '0;
              busy_d   = 1'b0;
            end else if (dr_q[16]) begin
              sticky_d = '0;
            end
          end else if (dr_sel == DR_DMI) begin
            if (busy_now) begin
              sticky_d = DMI_STAT_BUSY;
            end else if (sticky_q == '0 &&
                         (dmi_in.op == DMI_OP_READ || dmi_in.op == DMI_OP_WRITE)) begin
              req_d       = dmi_in;
              dmi_start_d = 1'b1;
              busy_d      = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      if (state == SHIFT_IR)      tdo_d = ir_shift_q[0];
      else if (state == SHIFT_DR) tdo_d = dr_q[0];
      else                        tdo_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q         <= IR_IDCODE;
      ir_shift_q   <= '0;
      dr_q         <= '0;
      tdo_q        <= 1'b0;
      dmi_start_q  <= 1'b0;
      req_q        <= '0;
      busy_q       <= 1'b0;
      sticky_q     <= '0;
      last_rdata_q <= '0;
    end else begin
      ir_q         <= ir_d;
      ir_shift_q   <= ir_shift_d;
      dr_q         <= dr_d;
      tdo_q        <= tdo_d;
      dmi_start_q  <= dmi_start_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      sticky_q     <= sticky_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  assign tdo         = tdo_q;
  assign dmi_start   = dmi_start_q;
  assign dmi_op      = req_q.op;
  assign dmi_address = req_q.addr;
  assign dmi_data_o  = req_q.data;

endmodule

// File: tb/tb_dtm_jtag.sv
// Directed bench for dtm_jtag: drives JTAG scans at clk/12 and models a DM
// that answers each dmi_start after a programmable number of clk.
module tb_dtm_jtag;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        dmi_start;
  logic        dmi_finish = 1'b0;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i = '0;

  int total = 0;
  int bad   = 0;

  int          start_cnt = 0;
  int          stab_err  = 0;
  int          dm_cnt    = 0;
  int          dm_delay  = 2;
  logic [31:0] dm_rdata  = '0;
  logic [6:0]  req_addr  = '0;
  logic [31:0] req_data  = '0;
  logic [1:0]  req_op    = '0;

  always #5 clk = ~clk;

  dtm_jtag dut (
    .clk        (clk),
    .rst        (rst),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .dmi_start  (dmi_start),
    .dmi_finish (dmi_finish),
    .dmi_op     (dmi_op),
    .dmi_address(dmi_address),
    .dmi_data_o (dmi_data_o),
    .dmi_data_i (dmi_data_i)
  );

  // DM model: counts starts, checks request stability while outstanding,
  // and pulses dmi_finish dm_delay clk after each start.
  always @(negedge clk) begin
    dmi_finish = 1'b0;
    if (dm_cnt > 0) begin
      if (dmi_address !== req_addr || dmi_data_o !== req_data || dmi_op !== req_op)
        stab_err++;
      dm_cnt--;
      if (dm_cnt == 0) begin
        dmi_finish = 1'b1;
        dmi_data_i = dm_rdata;
      end
    end
    if (dmi_start === 1'b1) begin
      start_cnt++;
      req_addr = dmi_address;
      req_data = dmi_data_o;
      req_op   = dmi_op;
      dm_cnt   = dm_delay;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // One tck period: low 6 clk (tdo sampled near the end), high 6 clk.
  task automatic tck_cycle(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    repeat (5) @(negedge clk);
    o = tdo;
    @(negedge clk);
    tck = 1'b1;
    repeat (6) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic goto_rti();
    logic o;
    repeat (5) tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  task automatic ir_scan(input logic [4:0] ir, output logic [4:0] out);
    logic o;
    out = '0;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, ir[i], o);
      out[i] = o;
    end
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  // Run-Test-Idle to Update-DR, shifting len bits LSB-first.
  task automatic dr_shift(input int len, input logic [40:0] din, output logic [40:0] dout);
    logic o;
    dout = '0;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], o);
      dout[i] = o;
    end
    tck_cycle(1'b1, 1'b0, o);
  endtask

  task automatic dr_scan(input int len, input logic [40:0] din, output logic [40:0] dout);
    logic o;
    dr_shift(len, din, dout);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  task automatic wait_dm(input int limit);
    int n = 0;
    while (dm_cnt != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dm_cnt != 0) begin
      bad++;
      $display("FAIL dm_wait_timeout waited=%0d limit=%0d", n, limit);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total += 5;
    if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b want=0", tdo); end
    if (dmi_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", dmi_start); end
    if (dmi_op !== 2'd0) begin bad++; $display("FAIL reset_op got=%h want=0", dmi_op); end
    if (dmi_address !== 7'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", dmi_address); end
    if (dmi_data_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", dmi_data_o); end
  endtask

  task automatic test_idcode();
    logic [4:0]  ir_out;
    logic [40:0] dout;
    goto_rti();
    dr_scan(32, 41'h0, dout);
    total++;
    if (dout[31:0] !== 32'h1000_0001) begin
      bad++; $display("FAIL idcode_default_ir got=%h want=10000001", dout[31:0]);
    end
    ir_scan(5'h01, ir_out);
    total++;
    if (ir_out !== 5'b00001) begin bad++; $display("FAIL ir_capture got=%b want=00001", ir_out); end
    dr_scan(32, 41'h0, dout);
    total++;
    if (dout[31:0] !== 32'h1000_0001) begin
      bad++; $display("FAIL idcode_scan got=%h want=10000001", dout[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [4:0]  irs [3];
    logic [4:0]  ir_out;
    logic [40:0] dout;
    irs = '{5'h1f, 5'h00, 5'h05};
    for (int k = 0; k < 3; k++) begin
      ir_scan(irs[k], ir_out);
      dr_scan(4, 41'b1101, dout);
      total++;
      if (dout[3:0] !== 4'b1010) begin
        bad++; $display("FAIL bypass_ir%h got=%b want=1010", irs[k], dout[3:0]);
      end
    end
  endtask

  task automatic test_dtmcs();
    logic [4:0]  ir_out;
    logic [40:0] dout;
    ir_scan(5'h10, ir_out);
    dr_scan(32, 41'h0, dout);
    total++;
    if (dout[31:0] !== 32'h0000_1071) begin
      bad++; $display("FAIL dtmcs_read got=%h want=00001071", dout[31:0]);
    end
  endtask

  task automatic test_dmi_write();
    logic [4:0]  ir_out;
    logic [40:0] dout;
    int          s0;
    dm_delay = 2;
    s0 = start_cnt;
    ir_scan(5'h11, ir_out);
    dr_scan(41, {7'h04, 32'hDEADBEEF, 2'd2}, dout);
    total++;
    if (dout !== 41'h0) begin bad++; $display("FAIL write_capture got=%h want=0", dout); end
    wait_dm(50);
    total += 5;
    if (start_cnt - s0 !== 1) begin bad++; $display("FAIL write_starts got=%0d want=1", start_cnt - s0); end
    if (req_addr !== 7'h04) begin bad++; $display("FAIL write_addr got=%h want=04", req_addr); end
    if (req_data !== 32'hDEADBEEF) begin bad++; $display("FAIL write_data got=%h want=deadbeef", req_data); end
    if (req_op !== 2'd2) begin bad++; $display("FAIL write_op got=%h want=2", req_op); end
    if (stab_err !== 0) begin bad++; $display("FAIL write_stable got=%0d want=0", stab_err); end
  endtask

  task automatic test_dmi_read();
    logic [40:0] dout;
    int          s0;
    dm_rdata = 32'h0000_0C82;
    s0 = start_cnt;
    dr_scan(41, {7'h11, 32'h0, 2'd1}, dout);
    total++;
    if (dout !== {7'h04, 32'h0, 2'd0}) begin
      bad++; $display("FAIL read_capture1 got=%h want=%h", dout, {7'h04, 32'h0, 2'd0});
    end
    wait_dm(50);
    dr_scan(41, 41'h0, dout);
    total += 3;
    if (dout !== {7'h11, 32'h0000_0C82, 2'd0}) begin
      bad++; $display("FAIL read_capture2 got=%h want=%h", dout, {7'h11, 32'h0000_0C82, 2'd0});
    end
    if (start_cnt - s0 !== 1) begin bad++; $display("FAIL read_starts got=%0d want=1", start_cnt - s0); end
    if (req_op !== 2'd1) begin bad++; $display("FAIL read_op got=%h want=1", req_op); end
  endtask

  task automatic test_busy_sticky();
    logic [4:0]  ir_out;
    logic [40:0] dout;
    int          s0;
    dm_delay = 1500;
    s0 = start_cnt;
    dr_scan(41, {7'h08, 32'h1234_5678, 2'd2}, dout);
    total++;
    if (dout !== {7'h11, 32'h0000_0C82, 2'd0}) begin
      bad++; $display("FAIL busy_capture1 got=%h want=%h", dout, {7'h11, 32'h0000_0C82, 2'd0});
    end
    dr_scan(41, {7'h09, 32'hCAFE_F00D, 2'd1}, dout);
    total += 2;
    if (dout !== {7'h08, 32'h0000_0C82, 2'd3}) begin
      bad++; $display("FAIL busy_capture2 got=%h want=%h", dout, {7'h08, 32'h0000_0C82, 2'd3});
    end
    if (start_cnt - s0 !== 1) begin bad++; $display("FAIL busy_starts got=%0d want=1", start_cnt - s0); end
    wait_dm(2000);
    dr_scan(41, 41'h0, dout);
    total++;
    if (dout !== {7'h08, 32'h0000_0C82, 2'd3}) begin
      bad++; $display("FAIL sticky_capture got=%h want=%h", dout, {7'h08, 32'h0000_0C82, 2'd3});
    end
    ir_scan(5'h10, ir_out);
    dr_scan(32, 41'h0, dout);
    total++;
    if (dout[31:0] !== 32'h0000_1C71) begin
      bad++; $display("FAIL dtmcs_sticky got=%h want=00001c71", dout[31:0]);
    end
    dr_scan(32, 41'h0_0001_0000, dout);
    total++;
    if (dout[31:0] !== 32'h0000_1C71) begin
      bad++; $display("FAIL dtmcs_before_clear got=%h want=00001c71", dout[31:0]);
    end
    dr_scan(32, 41'h0, dout);
    total++;
    if (dout[31:0] !== 32'h0000_1071) begin
      bad++; $display("FAIL dtmcs_cleared got=%h want=00001071", dout[31:0]);
    end
    dm_delay = 2;
    dm_rdata = 32'h0000_0055;
    ir_scan(5'h11, ir_out);
    dr_scan(41, {7'h02, 32'h0, 2'd1}, dout);
    total++;
    if (dout !== {7'h08, 32'h0000_0C82, 2'd0}) begin
      bad++; $display("FAIL after_clear_capture got=%h want=%h", dout, {7'h08, 32'h0000_0C82, 2'd0});
    end
    wait_dm(50);
    total += 2;
    if (start_cnt - s0 !== 2) begin bad++; $display("FAIL after_clear_starts got=%0d want=2", start_cnt - s0); end
    if (stab_err !== 0) begin bad++; $display("FAIL busy_stable got=%0d want=0", stab_err); end
  endtask

  task automatic test_reset_inflight();
    logic [4:0]  ir_out;
    logic [40:0] dout;
    logic        o;
    int          s0;
    int          n;
    dm_delay = 20;
    dm_rdata = 32'h0000_0099;
    s0 = start_cnt;
    dr_shift(41, {7'h05, 32'hA5A5_A5A5, 2'd2}, dout);
    tms = 1'b0;
    repeat (5) @(negedge clk);
    tck = 1'b1;
    n = 0;
    while (dmi_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (dmi_start !== 1'b1) begin bad++; $display("FAIL inflight_start got=%b want=1", dmi_start); end
    tck = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total += 5;
    if (tdo !== 1'b0) begin bad++; $display("FAIL rst_tdo got=%b want=0", tdo); end
    if (dmi_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", dmi_start); end
    if (dmi_op !== 2'd0) begin bad++; $display("FAIL rst_op got=%h want=0", dmi_op); end
    if (dmi_address !== 7'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", dmi_address); end
    if (dmi_data_o !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", dmi_data_o); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (start_cnt - s0 !== 1) begin bad++; $display("FAIL rst_starts got=%0d want=1", start_cnt - s0); end
    tck_cycle(1'b0, 1'b0, o);
    dr_scan(32, 41'h0, dout);
    total++;
    if (dout[31:0] !== 32'h1000_0001) begin
      bad++; $display("FAIL rst_idcode got=%h want=10000001", dout[31:0]);
    end
    ir_scan(5'h11, ir_out);
    dr_scan(41, 41'h0, dout);
    total++;
    if (dout !== 41'h0) begin bad++; $display("FAIL rst_dmi_capture got=%h want=0", dout); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idcode();
    test_bypass();
    test_dtmcs();
    test_dmi_write();
    test_dmi_read();
    test_busy_sticky();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
